// File: rtl/eq_seq.sv
// eq_seq: bit-serial equality comparator, LSB first, one bit per cycle with early exit.
// Ports: iClk/iReset (async, active-high), iStart/iA/iB request, oBusy/oDone/oEq/oMisIdx status.
// Latency: DONE entered k+1 edges after accept (mismatch at bit k) or WIDTH edges (equal); iStart ignored while busy.

// eq1: single-bit equality cell, the only per-bit comparator used by eq_seq.
// Ports: iA, iB operand bits; oEq = 1 when they match.
// Purely combinational.
module eq1 (
  input  logic iA,
  input  logic iB,
  output logic oEq
);
  assign oEq = ~(iA ^ iB);
endmodule

module eq_seq #(
  parameter int WIDTH = 8
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic                     iStart,
  input  logic [WIDTH-1:0]         iA,
  input  logic [WIDTH-1:0]         iB,
  output logic                     oBusy,
  output logic                     oDone,
  output logic                     oEq,
  output logic [$clog2(WIDTH)-1:0] oMisIdx
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [IW-1:0]    idx;
  logic             bit_eq;

  // Operands are shifted right each RUN cycle, so bit 0 of the shift
  // registers is always captured bit [idx].
  eq1 u_eq1 (
    .iA  (a_sh[0]),
    .iB  (b_sh[0]),
    .oEq (bit_eq)
  );

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      idx     <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oEq     <= 1'b0;
      oMisIdx <= '0;
    end else begin
      case (state)
        IDLE: begin
          oDone <= 1'b0;
          if (iStart) begin
            a_sh  <= iA;
            b_sh  <= iB;
            idx   <= '0;
            oBusy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (!bit_eq) begin
            // Early exit: remaining bits are never examined.
            state   <= DONE;
            oDone   <= 1'b1;
            oEq     <= 1'b0;
            oMisIdx <= idx;
          end else if (idx == LAST) begin
            state   <= DONE;
            oDone   <= 1'b1;
            oEq     <= 1'b1;
            oMisIdx <= '0;
          end else begin
            idx  <= idx + IW'(1);
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
          end
        end
        DONE: begin
          state <= IDLE;
          oDone <= 1'b0;
          oBusy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          oDone <= 1'b0;
          oBusy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/eq_seq.md
EQ_SEQ -- requirements
Module: eq_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 iClk  input  1  clock; all state changes on rising edge.
REQ-003 iReset  input  1  reset, asynchronous, active-high.
REQ-004 iStart  input  1  request to begin a comparison; sampled only in IDLE.
REQ-005 iA  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 iB  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 oBusy  output  1  high in RUN and DONE states.
REQ-008 oDone  output  1  one-cycle pulse; high only in DONE state.
REQ-009 oEq  output  1  result of last completed comparison: 1 = A equals B.
REQ-010 oMisIdx  output  $clog2(WIDTH)  bit index of first mismatch, LSB-first; 0 when oEq=1.

Function
REQ-011 The block SHALL compare the captured operands one bit per cycle, LSB first, using a single internal eq1 instance (ports iA, iB, oEq) as the only per-bit comparator.
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 IDLE: iStart=1 at an edge captures iA/iB into shift registers, clears bit index to 0, enters RUN; iStart=0 stays IDLE.
REQ-014 RUN: each edge presents captured bit [idx] of A and B to eq1 and evaluates its oEq.
REQ-015 RUN, eq1 oEq=0: enter DONE, latch oEq=0, latch oMisIdx=idx (early termination; remaining bits not compared).
REQ-016 RUN, eq1 oEq=1 and idx<WIDTH-1: increment idx, stay RUN.
REQ-017 RUN, eq1 oEq=1 and idx=WIDTH-1: enter DONE, latch oEq=1, oMisIdx=0.
REQ-018 DONE: lasts exactly one cycle, then IDLE unconditionally.
REQ-019 Latency: oDone SHALL assert k+2 cycles after the accepting edge for first mismatch at bit k; WIDTH+1 cycles for equal operands.
REQ-020 iStart while oBusy=1 (RUN or DONE) SHALL be ignored and not queued; a new request is accepted no earlier than the first IDLE cycle.
REQ-021 iA/iB changes after the accepting edge SHALL NOT affect the result in progress.
REQ-022 oEq and oMisIdx SHALL hold their latched values through IDLE until the next comparison reaches DONE; they SHALL NOT change during RUN.
REQ-023 idx counter SHALL never exceed WIDTH-1; no wrap-around occurs.

Reset
REQ-024 iReset=1 SHALL immediately, without a clock edge, force state IDLE, idx=0, oBusy=0, oDone=0, oEq=0, oMisIdx=0, and clear captured operands.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the comparison with no oDone pulse; operation resumes from IDLE on the first edge after deassertion.
REQ-026 iStart high during the deassertion edge SHALL be treated as a normal IDLE request on that edge.

Verification (WIDTH=8)
REQ-027 A=8'hA5, B=8'hA5, iStart pulse -> oBusy for 9 cycles, oDone 9 cycles after accept, oEq=1, oMisIdx=0.
REQ-028 A=8'hA5, B=8'hA4 -> mismatch bit 0, oDone 2 cycles after accept, oEq=0, oMisIdx=0.
REQ-029 A=8'h00, B=8'h80 -> oDone 9 cycles after accept, oEq=0, oMisIdx=7; then A=B=8'h3C -> oEq=1 with no stale oMisIdx.
REQ-030 iStart held high continuously with A=B=8'hFF -> back-to-back comparisons, one accept per 10 cycles (IDLE cycle between), each oDone single-cycle with oEq=1.
REQ-031 Operands changed to unequal values 1 cycle after accept of A=B=8'h5A -> oEq=1 (captured values used).
REQ-032 Async iReset pulse mid-RUN (bit 3 of 8'h12 vs 8'h12), between clock edges -> outputs cleared immediately, no oDone; next request completes normally with oEq=1.
